// File: rtl/chacha_keystream_gen.sv
// chacha_keystream_gen: ChaCha keystream engine with RPC-way round unrolling and a one-deep output buffer.
// Optional HChaCha subkey mode is enabled by defining CHACHA_HCHACHA_EN.
module chacha_keystream_gen #(
    parameter int NUM_ROUNDS = 20,
    parameter int RPC        = 1,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [255:0]     cmd_key,
    input  logic [95:0]      cmd_nonce,
    input  logic [31:0]      cmd_ctr,
    input  logic [CNT_W-1:0] cmd_nblk,
    input  logic             cmd_hmode,
    output logic [511:0]     ks_data,
    output logic             ks_valid,
    input  logic             ks_ready,
    output logic             ks_last,
    output logic             busy,
    output logic             ctr_err
);
    localparam int RW = $clog2(NUM_ROUNDS + 1);
    localparam logic [127:0] SIGMA = 128'h61707865_3320646e_79622d32_6b206574;

    typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;

    state_t state, nxt;
    logic [511:0] x, rounds, orig, ff, blk;
    logic [255:0] key;
    logic [95:0] nonce;
    logic [31:0] ctr;
    logic [CNT_W-1:0] rem;
    logic [RW-1:0] rnd;
    logic hm, done, fin, free, wr, wrap, last_blk;

    function automatic logic [31:0] rotl(input logic [31:0] v, input int n);
        return (v << n) | (v >> (32 - n));
    endfunction

    // One column (d=0) or diagonal (d=1) round over the packed state, word i at [511-32i].
    function automatic logic [511:0] dround(input logic [511:0] s, input logic d);
        logic [31:0] w [16];
        logic [511:0] r;
        int a, b, c, e;
        for (int i = 0; i < 16; i++) w[i] = s[511-32*i -: 32];
        for (int i = 0; i < 4; i++) begin
            a = i;
            b = 4 + ((i + (d ? 1 : 0)) & 3);
            c = 8 + ((i + (d ? 2 : 0)) & 3);
            e = 12 + ((i + (d ? 3 : 0)) & 3);
            w[a] = w[a] + w[b]; w[e] = rotl(w[e] ^ w[a], 16);
            w[c] = w[c] + w[e]; w[b] = rotl(w[b] ^ w[c], 12);
            w[a] = w[a] + w[b]; w[e] = rotl(w[e] ^ w[a], 8);
            w[c] = w[c] + w[e]; w[b] = rotl(w[b] ^ w[c], 7);
        end
        r = '0;
        for (int i = 0; i < 16; i++) r[511-32*i -: 32] = w[i];
        return r;
    endfunction

    assign orig      = {SIGMA, key, ctr, nonce};
    assign done      = rnd == RW'(NUM_ROUNDS);
    assign fin       = state == HOLD || (state == RUN && done);
    assign free      = !ks_valid || ks_ready;
    assign wr        = fin && free;
    assign wrap      = ctr == 32'hffff_ffff && rem > CNT_W'(1);
    assign last_blk  = hm || rem <= CNT_W'(1) || wrap;
    assign cmd_ready = state == IDLE;
    assign busy      = state != IDLE || ks_valid;

    // RPC rounds per clock; parity of the absolute round index picks column vs diagonal.
    always_comb begin
        rounds = x;
        for (int k = 0; k < RPC; k++) rounds = dround(rounds, rnd[0] ^ k[0]);
    end

    // Feed-forward: finished working state plus the original input block, word-wise.
    always_comb begin
        ff = '0;
        for (int i = 0; i < 16; i++) ff[511-32*i -: 32] = x[511-32*i -: 32] + orig[511-32*i -: 32];
    end

`ifdef CHACHA_HCHACHA_EN
    assign blk = hm ? {x[511:384], x[127:0], 256'b0} : ff;

    // HChaCha mode flag captured with the command.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) hm <= 1'b0;
        else if (state == IDLE && cmd_valid) hm <= cmd_hmode;
    end
`else
    logic unused_hmode;
    assign unused_hmode = cmd_hmode;
    assign hm  = 1'b0;
    assign blk = ff;
`endif

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else state <= nxt;
    end

    // Next state: finished blocks park in HOLD until the output buffer frees.
    always_comb begin
        nxt = state;
        if (state == IDLE) nxt = cmd_valid ? RUN : IDLE;
        else if (fin) nxt = !wr ? HOLD : last_blk ? IDLE : RUN;
    end

    // Command capture, round iteration, block hand-off and output buffer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x        <= '0;
            key      <= '0;
            nonce    <= '0;
            ctr      <= '0;
            rem      <= '0;
            rnd      <= '0;
            ks_data  <= '0;
            ks_valid <= 1'b0;
            ks_last  <= 1'b0;
            ctr_err  <= 1'b0;
        end else begin
            if (state == IDLE && cmd_valid) begin
                key     <= cmd_key;
                nonce   <= cmd_nonce;
                ctr     <= cmd_ctr;
                rem     <= cmd_nblk == '0 ? CNT_W'(1) : cmd_nblk;
                rnd     <= '0;
                ctr_err <= 1'b0;
                x       <= {SIGMA, cmd_key, cmd_ctr, cmd_nonce};
            end else if (state == RUN && !done) begin
                x   <= rounds;
                rnd <= rnd + RW'(RPC);
            end else if (wr && !last_blk) begin
                rem <= rem - CNT_W'(1);
                ctr <= ctr + 32'd1;
                rnd <= '0;
                x   <= {SIGMA, key, ctr + 32'd1, nonce};
            end
            if (wr) begin
                ks_data  <= blk;
                ks_valid <= 1'b1;
                ks_last  <= last_blk;
                ctr_err  <= ctr_err | (!hm && wrap);
            end else if (ks_valid && ks_ready) begin
                ks_valid <= 1'b0;
                ks_last  <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_chacha_keystream_gen.sv
// tb_chacha_keystream_gen: directed checks of the ChaCha keystream engine against RFC 8439 vectors.
module tb_chacha_keystream_gen;
    localparam int NR  = 20;
    localparam int RPC = 1;
    localparam int CW  = 16;
    localparam int LAT = NR / RPC + 1;
    localparam logic [255:0] K1 = {32'h03020100, 32'h07060504, 32'h0b0a0908, 32'h0f0e0d0c,
                                   32'h13121110, 32'h17161514, 32'h1b1a1918, 32'h1f1e1d1c};
    localparam logic [95:0]  N1 = {32'h09000000, 32'h4a000000, 32'h00000000};

    logic clk = 1'b0;
    logic rst, cmd_valid, cmd_ready, cmd_hmode, ks_valid, ks_ready, ks_last, busy, ctr_err;
    logic [255:0] cmd_key;
    logic [95:0] cmd_nonce;
    logic [31:0] cmd_ctr;
    logic [CW-1:0] cmd_nblk;
    logic [511:0] ks_data;

    int checks = 0;
    int errors = 0;
    logic [511:0] blk [8];
    logic lst [8];
    logic rdy [8];
    int at [8];
    int got;

    chacha_keystream_gen #(.NUM_ROUNDS(NR), .RPC(RPC), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_key(cmd_key), .cmd_nonce(cmd_nonce), .cmd_ctr(cmd_ctr), .cmd_nblk(cmd_nblk),
        .cmd_hmode(cmd_hmode), .ks_data(ks_data), .ks_valid(ks_valid), .ks_ready(ks_ready),
        .ks_last(ks_last), .busy(busy), .ctr_err(ctr_err)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog got %0d exp finish", 0);
        $fatal(1);
    end

    task chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %08h exp %08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] rol(input logic [31:0] v, input int s);
        return (v << s) | (v >> (32 - s));
    endfunction

    // Reference ChaCha block: quarter-round index table, NR/2 double rounds, feed-forward.
    function automatic logic [511:0] ref_block(input logic [255:0] k, input logic [31:0] c, input logic [95:0] n);
        logic [31:0] s [16];
        logic [31:0] w [16];
        logic [15:0] t [8];
        logic [511:0] r;
        int a, b, cc, d;
        t[0] = 16'h048c; t[1] = 16'h159d; t[2] = 16'h26ae; t[3] = 16'h37bf;
        t[4] = 16'h05af; t[5] = 16'h16bc; t[6] = 16'h278d; t[7] = 16'h349e;
        s[0] = 32'h61707865; s[1] = 32'h3320646e; s[2] = 32'h79622d32; s[3] = 32'h6b206574;
        for (int i = 0; i < 8; i++) s[4+i] = k[255-32*i -: 32];
        s[12] = c;
        for (int i = 0; i < 3; i++) s[13+i] = n[95-32*i -: 32];
        for (int i = 0; i < 16; i++) w[i] = s[i];
        for (int r2 = 0; r2 < NR / 2; r2++)
            for (int q = 0; q < 8; q++) begin
                a = int'(t[q][15:12]); b = int'(t[q][11:8]); cc = int'(t[q][7:4]); d = int'(t[q][3:0]);
                w[a] = w[a] + w[b]; w[d] = rol(w[d] ^ w[a], 16);
                w[cc] = w[cc] + w[d]; w[b] = rol(w[b] ^ w[cc], 12);
                w[a] = w[a] + w[b]; w[d] = rol(w[d] ^ w[a], 8);
                w[cc] = w[cc] + w[d]; w[b] = rol(w[b] ^ w[cc], 7);
            end
        r = '0;
        for (int i = 0; i < 16; i++) r[511-32*i -: 32] = w[i] + s[i];
        return r;
    endfunction

    function automatic logic [31:0] wd(input logic [511:0] v, input int i);
        return v[511-32*i -: 32];
    endfunction

    task chk_blk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        for (int i = 0; i < 16; i++) chk($sformatf("%s_w%0d", tag, i), wd(obs, i), wd(exp, i));
    endtask

    // Present one command for a single edge; called #1 after a rising edge.
    task send(input logic [255:0] k, input logic [31:0] c, input logic [95:0] n, input logic [CW-1:0] nb, input logic h);
        chk("cmd_ready_pre", 32'(cmd_ready), 32'd1);
        cmd_key = k; cmd_ctr = c; cmd_nonce = n; cmd_nblk = nb; cmd_hmode = h; cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    // Record every block that transfers, with its cycle offset, within a cycle budget.
    task collect(input int n, input int budget);
        got = 0;
        for (int c = 0; c < budget && got < n; c++) begin
            if (ks_valid && ks_ready) begin
                blk[got] = ks_data; lst[got] = ks_last; rdy[got] = cmd_ready; at[got] = c;
                got++;
            end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        logic [511:0] hb;
        int first;
        rst = 1'b1; cmd_valid = 1'b0; ks_ready = 1'b0; cmd_hmode = 1'b0;
        cmd_key = '0; cmd_nonce = '0; cmd_ctr = '0; cmd_nblk = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("rst_ks_valid", 32'(ks_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // RFC 8439 block vector, single block, latency.
        ks_ready = 1'b1;
        send(K1, 32'd1, N1, CW'(1), 1'b0);
        collect(1, 100);
        chk("t1_count", 32'(got), 32'd1);
        chk("t1_latency", 32'(at[0]), 32'(LAT));
        chk("t1_word0", wd(blk[0], 0), 32'he4e7f110);
        chk("t1_word15", wd(blk[0], 15), 32'h4e3c50a2);
        chk("t1_last", 32'(lst[0]), 32'd1);
        chk_blk("t1_ref", blk[0], ref_block(K1, 32'd1, N1));

        // Four back-to-back blocks with the counter stepping.
        send(K1, 32'd1, N1, CW'(4), 1'b0);
        collect(4, 200);
        chk("t2_count", 32'(got), 32'd4);
        for (int b = 0; b < 4; b++) begin
            chk($sformatf("t2_at%0d", b), 32'(at[b]), 32'(LAT * (b + 1)));
            chk($sformatf("t2_last%0d", b), 32'(lst[b]), 32'(b == 3));
            chk($sformatf("t2_rdy%0d", b), 32'(rdy[b]), 32'(b == 3));
            chk_blk($sformatf("t2_b%0d", b), blk[b], ref_block(K1, 32'(b + 1), N1));
        end

        // Backpressure: hold the consumer off for 60 cycles.
        ks_ready = 1'b0;
        send(K1, 32'd1, N1, CW'(3), 1'b0);
        first = 0;
        hb = '0;
        for (int c = 1; c <= 60; c++) begin
            @(posedge clk); #1;
            if (ks_valid && first == 0) begin first = c; hb = ks_data; end
        end
        chk("t3_first", 32'(first), 32'(LAT));
        chk("t3_stable", 32'(ks_data == hb), 32'd1);
        chk("t3_busy", 32'(busy), 32'd1);
        chk("t3_cmd_ready", 32'(cmd_ready), 32'd0);
        chk("t3_last_held", 32'(ks_last), 32'd0);
        ks_ready = 1'b1;
        collect(4, 120);
        chk("t3_count", 32'(got), 32'd3);
        for (int b = 0; b < 3; b++) begin
            chk($sformatf("t3_last%0d", b), 32'(lst[b]), 32'(b == 2));
            chk_blk($sformatf("t3_b%0d", b), blk[b], ref_block(K1, 32'(b + 1), N1));
        end

        // Counter wrap terminates the command after the FFFFFFFF block.
        send(K1, 32'hffff_fffe, N1, CW'(5), 1'b0);
        collect(5, 150);
        chk("t4_count", 32'(got), 32'd2);
        chk("t4_last0", 32'(lst[0]), 32'd0);
        chk("t4_last1", 32'(lst[1]), 32'd1);
        chk("t4_word0_b0", wd(blk[0], 0), wd(ref_block(K1, 32'hffff_fffe, N1), 0));
        chk("t4_word0_b1", wd(blk[1], 0), wd(ref_block(K1, 32'hffff_ffff, N1), 0));
        chk("t4_ctr_err", 32'(ctr_err), 32'd1);
        repeat (5) @(posedge clk);
        #1;
        chk("t4_ctr_err_sticky", 32'(ctr_err), 32'd1);
        chk("t4_idle", 32'(busy), 32'd0);
        send(K1, 32'd1, N1, CW'(1), 1'b0);
        chk("t4_ctr_err_clr", 32'(ctr_err), 32'd0);
        collect(1, 100);
        chk("t4_after", wd(blk[0], 0), 32'he4e7f110);

        // Async reset in the middle of the round iterations.
        send(K1, 32'd1, N1, CW'(2), 1'b0);
        repeat (10) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("t5_run_busy", 32'(busy), 32'd0);
        chk("t5_run_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("t5_run_valid", 32'(ks_valid), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Async reset while a block sits unconsumed with ctr_err raised.
        ks_ready = 1'b0;
        send(K1, 32'hffff_ffff, N1, CW'(3), 1'b0);
        repeat (LAT + 3) @(posedge clk);
        #3;
        chk("t5_pre_valid", 32'(ks_valid), 32'd1);
        chk("t5_pre_err", 32'(ctr_err), 32'd1);
        rst = 1'b1;
        #1;
        chk("t5_valid", 32'(ks_valid), 32'd0);
        chk("t5_data", 32'(|ks_data), 32'd0);
        chk("t5_last", 32'(ks_last), 32'd0);
        chk("t5_err", 32'(ctr_err), 32'd0);
        chk("t5_busy", 32'(busy), 32'd0);
        chk("t5_cmd_ready", 32'(cmd_ready), 32'd1);
        rst = 1'b0;
        @(posedge clk); #1;
        ks_ready = 1'b1;
        send(K1, 32'd1, N1, CW'(1), 1'b0);
        collect(1, 100);
        chk("t5_fresh_count", 32'(got), 32'd1);
        chk("t5_fresh_w0", wd(blk[0], 0), 32'he4e7f110);
        chk("t5_fresh_w15", wd(blk[0], 15), 32'h4e3c50a2);

`ifdef CHACHA_HCHACHA_EN
        // HChaCha subkey derivation: single block, no feed-forward.
        send(K1, 32'h09000000, {32'h4a000000, 32'h00000000, 32'h27594131}, CW'(7), 1'b1);
        collect(2, 120);
        chk("t6_count", 32'(got), 32'd1);
        chk("t6_last", 32'(lst[0]), 32'd1);
        chk_blk("t6_sub", blk[0], {32'h423b4182, 32'hfe7bb227, 32'h50420ed3, 32'h737d878a,
                                   32'hd5e4f9a0, 32'h53a8748a, 32'h13c42ec1, 32'hdcecd326, 256'b0});
`else
        // Without HChaCha support the mode bit has no effect.
        send(K1, 32'd1, N1, CW'(1), 1'b1);
        collect(2, 120);
        chk("t6_count", 32'(got), 32'd1);
        chk("t6_word0", wd(blk[0], 0), 32'he4e7f110);
        chk("t6_last", 32'(lst[0]), 32'd1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
